// File: rtl/aes32_pipe_unit_pkg.sv
// Shared AES32 types and GF(2^8) helpers: op encoding, S-box environment
// select, field arithmetic and the forward/inverse S-box transforms.
package aes32_pipe_unit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ESI  = 2'd0,
    ESMI = 2'd1,
    DSI  = 2'd2,
    DSMI = 2'd3
  } aes_op_e;

  typedef enum logic {
    FPGA = 1'b0,
    ASIC = 1'b1
  } env_e;

  function automatic logic aes_is_dec(aes_op_e op);
    return op[1];
  endfunction

  function automatic logic aes_is_mix(aes_op_e op);
    return op[0];
  endfunction

  function automatic logic [7:0] xtime2(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant, enough for every MixColumns coefficient.
  function automatic logic [7:0] gfmul4(logic [7:0] a, logic [3:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime2(x);
    end
    return acc;
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime2(x);
    end
    return acc;
  endfunction

  // a^254 by square-and-multiply: builds a^(2^k-1) up to a^127, then squares.
  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] x;
    x = a;
    for (int k = 0; k < 6; k++) x = gf_mul(gf_mul(x, x), a);
    return gf_mul(x, x);
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_fwd_calc(logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv_calc(logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // Elaboration-time ROM image for the LUT-style S-box.
  function automatic logic [255:0][7:0] sbox_table(logic dec);
    logic [255:0][7:0] t;
    for (int i = 0; i < 256; i++)
      t[i] = dec ? sbox_inv_calc(8'(i)) : sbox_fwd_calc(8'(i));
    return t;
  endfunction

endpackage

// File: rtl/aes32_pipe_unit_sbox_dual.sv
// Forward and inverse AES S-box behind one byte port; dec picks the inverse.
// FPGA builds use a ROM table, ASIC builds use the inversion/affine logic.
module aes32_sbox_dual
  import aes32_pipe_unit_pkg::*;
#(
  parameter env_e Environment = ASIC
) (
  input  logic [7:0] in,
  input  logic       dec,
  output logic [7:0] fx
);

  if (Environment == FPGA) begin : g_lut
    localparam logic [255:0][7:0] FWD_LUT = sbox_table(1'b0);
    localparam logic [255:0][7:0] INV_LUT = sbox_table(1'b1);
    assign fx = dec ? INV_LUT[in] : FWD_LUT[in];
  end else begin : g_gate
    assign fx = dec ? sbox_inv_calc(in) : sbox_fwd_calc(in);
  end

endmodule

// File: rtl/aes32_pipe_unit.sv
// Pipelined AES32 byte unit (aes32esi/esmi/dsi/dsmi) with a valid/ready
// handshake on both sides, flush, and 1- or 2-stage bubble-collapsing pipe.
module aes32_pipe_unit
  import aes32_pipe_unit_pkg::*;
#(
  parameter env_e Environment  = ASIC,
  parameter int   STAGES       = 2,
  parameter bit   LOGIC_GATING = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  aes_op_e           op_i,
  input  logic [DATA_W-1:0] rs1_i,
  input  logic [DATA_W-1:0] rs2_i,
  input  logic [1:0]        bs_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] rd_o
);

  function automatic logic [DATA_W-1:0] mix_rot_xor(aes_op_e op, logic [1:0] bs,
                                                    logic [7:0] s, logic [DATA_W-1:0] rs1);
    logic [DATA_W-1:0]   mixed;
    logic [2*DATA_W-1:0] dbl;
    if (!aes_is_mix(op))
      mixed = {24'b0, s};
    else if (aes_is_dec(op))
      mixed = {gfmul4(s, 4'hb), gfmul4(s, 4'hd), gfmul4(s, 4'h9), gfmul4(s, 4'he)};
    else
      mixed = {gfmul4(s, 4'h3), s, s, xtime2(s)};
    dbl = {mixed, mixed} << {bs, 3'b000};
    return dbl[2*DATA_W-1 -: DATA_W] ^ rs1;
  endfunction

  logic [DATA_W-1:0] rs1_g;
  logic [DATA_W-1:0] rs2_g;
  logic [7:0]        byte_sel;
  logic [7:0]        sub_byte;
  logic              sub_dec;
  logic              ready_p0;
  logic              accept_p0;

  assign rs1_g     = LOGIC_GATING ? (rs1_i & {DATA_W{in_valid_i}}) : rs1_i;
  assign rs2_g     = LOGIC_GATING ? (rs2_i & {DATA_W{in_valid_i}}) : rs2_i;
  assign byte_sel  = rs2_g[{bs_i, 3'b000} +: 8];
  assign sub_dec   = aes_is_dec(op_i);

  // Flush and reset both refuse new work in the cycle they are asserted.
  assign in_ready_o = ready_p0 && !flush_i && !reset;
  assign accept_p0  = in_valid_i && in_ready_o;

  aes32_sbox_dual #(.Environment(Environment)) u_sbox (
    .in  (byte_sel),
    .dec (sub_dec),
    .fx  (sub_byte)
  );

  if (STAGES == 1) begin : g_one
    logic              vld_p1;
    logic [DATA_W-1:0] rd_p1;

    assign ready_p0 = !vld_p1 || out_ready_i;

    // ---- stage p1: full result registered
    always_ff @(posedge clk) begin
      if (reset || flush_i) vld_p1 <= 1'b0;
      else if (ready_p0)    vld_p1 <= accept_p0;
    end

    always_ff @(posedge clk) begin
      if (reset)          rd_p1 <= '0;
      else if (accept_p0) rd_p1 <= mix_rot_xor(op_i, bs_i, sub_byte, rs1_g);
    end

    assign out_valid_o = vld_p1;
    assign rd_o        = rd_p1;
  end else begin : g_two
    logic              vld_p1;
    logic              vld_p2;
    aes_op_e           op_p1;
    logic [1:0]        bs_p1;
    logic [7:0]        s_p1;
    logic [DATA_W-1:0] rs1_p1;
    logic [DATA_W-1:0] rd_p2;
    logic              adv_p1;

    assign adv_p1   = !vld_p2 || out_ready_i;
    assign ready_p0 = !vld_p1 || adv_p1;

    always_ff @(posedge clk) begin
      if (reset || flush_i) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        if (ready_p0) vld_p1 <= accept_p0;
        if (adv_p1)   vld_p2 <= vld_p1;
      end
    end

    // ---- stage p1: S-box output plus the operands needed to finish
    always_ff @(posedge clk) begin
      if (accept_p0) begin
        s_p1   <= sub_byte;
        op_p1  <= op_i;
        bs_p1  <= bs_i;
        rs1_p1 <= rs1_g;
      end
    end

    // ---- stage p2: mix, rotate, xor
    always_ff @(posedge clk) begin
      if (reset)                              rd_p2 <= '0;
      else if (adv_p1 && vld_p1 && !flush_i) rd_p2 <= mix_rot_xor(op_p1, bs_p1, s_p1, rs1_p1);
    end

    assign out_valid_o = vld_p2;
    assign rd_o        = rd_p2;
  end

endmodule
